// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/add/sub/shift in 1 cycle, iterative unsigned mul/div in WIDTH+1 cycles.
// Latency 1 or WIDTH+1 from start to done_o; start_i is ignored while busy_o=1 (no queueing).
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       func_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] out_o,
    output logic             c_o,
    output logic             v_o,
    output logic             z_o,
    output logic             n_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH-1:0] sra_w;
    logic [WIDTH-1:0] srl_w;
    logic [WIDTH-1:0] q_res;
    logic             q_c;
    logic             q_v;
    logic             is_iter;

    always_comb begin
        add_w   = {1'b0, in1_i} + {1'b0, in2_i};
        sub_w   = {1'b0, in1_i} - {1'b0, in2_i};
        shl_w   = {1'b0, in1_i} << in2_i;
        sra_w   = $signed(in1_i) >>> in2_i;
        srl_w   = in1_i >> in2_i;
        is_iter = (MUL_EN && (func_i == 4'h8 || func_i == 4'h9)) ||
                  (DIV_EN && (func_i == 4'hA || func_i == 4'hB));
        q_res   = '0;
        q_c     = 1'b0;
        q_v     = 1'b0;
        case (func_i)
            4'h0: q_res = in1_i & in2_i;
            4'h1: q_res = in1_i | in2_i;
            4'h2: begin
                q_res = add_w[WIDTH-1:0];
                q_c   = add_w[WIDTH];
                q_v   = (in1_i[WIDTH-1] == in2_i[WIDTH-1]) && (add_w[WIDTH-1] != in1_i[WIDTH-1]);
            end
            4'h3: begin
                q_res = sub_w[WIDTH-1:0];
                q_c   = sub_w[WIDTH];
                q_v   = (in1_i[WIDTH-1] != in2_i[WIDTH-1]) && (sub_w[WIDTH-1] != in1_i[WIDTH-1]);
            end
            // Bit WIDTH of the widened shift is exactly the last bit shifted out.
            4'h4: begin
                q_res = shl_w[WIDTH-1:0];
                q_c   = shl_w[WIDTH];
                q_v   = shl_w[WIDTH-1] ^ shl_w[WIDTH];
            end
            4'h5: begin
                q_res = sra_w;
                q_v   = sra_w[WIDTH-1];
            end
            4'h6: begin
                q_res = srl_w;
                q_v   = srl_w[WIDTH-1];
            end
            4'h7: q_res = in1_i ^ in2_i;
            default: q_v = 1'b1;
        endcase
    end

    // One iteration step: {hi,lo} is product accumulator for mul, {remainder,quotient} for div.
    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] mhi;
    logic [WIDTH-1:0] mlo;
    logic [WIDTH:0]   rsh;
    logic             ge;
    logic [WIDTH-1:0] rdf;
    logic [WIDTH-1:0] dhi;
    logic [WIDTH-1:0] dlo;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c;
    logic             fin_v;

    always_comb begin
        msum = {1'b0, hi} + (lo[0] ? {1'b0, op_a} : '0);
        mhi  = msum[WIDTH:1];
        mlo  = {msum[0], lo[WIDTH-1:1]};
        rsh  = {hi, lo[WIDTH-1]};
        ge   = rsh >= {1'b0, op_b};
        rdf  = rsh[WIDTH-1:0] - op_b;
        dhi  = ge ? rdf : rsh[WIDTH-1:0];
        dlo  = {lo[WIDTH-2:0], ge};
        fin_res = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        case (op_sel)
            2'd0: begin
                fin_res = mlo;
                fin_c   = |mhi;
                fin_v   = |mhi;
            end
            2'd1: fin_res = mhi;
            2'd2: begin
                fin_res = dlo;
                fin_v   = ~|op_b;
            end
            default: begin
                fin_res = dhi;
                fin_v   = ~|op_b;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            out_o  <= '0;
            c_o    <= 1'b0;
            v_o    <= 1'b0;
            cnt    <= '0;
            op_sel <= '0;
            op_a   <= '0;
            op_b   <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start_i) begin
                        if (is_iter) begin
                            state  <= ITER;
                            busy_o <= 1'b1;
                            cnt    <= CW'(WIDTH - 1);
                            op_sel <= func_i[1:0];
                            op_a   <= in1_i;
                            op_b   <= in2_i;
                            hi     <= '0;
                            lo     <= func_i[1] ? in1_i : in2_i;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            out_o  <= q_res;
                            c_o    <= q_c;
                            v_o    <= q_v;
                        end
                    end
                end
                ITER: begin
                    hi  <= op_sel[1] ? dhi : mhi;
                    lo  <= op_sel[1] ? dlo : mlo;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        out_o  <= fin_res;
                        c_o    <= fin_c;
                        v_o    <= fin_v;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign z_o = (out_o == '0);
    assign n_o = out_o[WIDTH-1];

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboarded random/directed bench for alu_mc against a plain-arithmetic reference model.
module tb_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [3:0]   func_i;
    logic [W-1:0] in1_i;
    logic [W-1:0] in2_i;
    logic         busy_o, done_o, c_o, v_o, z_o, n_o;
    logic [W-1:0] out_o;

    logic         s8;
    logic [3:0]   f8;
    logic [7:0]   a8, b8, out8;
    logic         busy8, done8, c8, v8, z8, n8;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .func_i(func_i),
        .in1_i(in1_i), .in2_i(in2_i), .busy_o(busy_o), .done_o(done_o),
        .out_o(out_o), .c_o(c_o), .v_o(v_o), .z_o(z_o), .n_o(n_o)
    );

    alu_mc #(.WIDTH(8), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut8 (
        .clk_i(clk), .rst_i(rst_i), .start_i(s8), .func_i(f8),
        .in1_i(a8), .in2_i(b8), .busy_o(busy8), .done_o(done8),
        .out_o(out8), .c_o(c8), .v_o(v8), .z_o(z8), .n_o(n8)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           at;
    } exp_t;

    exp_t scb[$];
    exp_t mx;
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    int   free_at = 0;
    int   busy_last = -1;
    int   last_e = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic v);
        longint          sa, sbv, s;
        longint unsigned p;
        int              idx;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = 64'(a) * 64'(b);
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (f)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h7: r = a ^ b;
            4'h2: begin
                s = sa + sbv;
                r = a + b;
                c = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h3: begin
                s = sa - sbv;
                r = a - b;
                c = a < b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h4: begin
                if (b == 0) r = a;
                else if (b < W) begin
                    r   = a << b;
                    idx = W - int'(b);
                    c   = a[idx];
                end else if (b == W) c = a[0];
                v = r[W-1] ^ c;
            end
            4'h5: begin
                r = (b >= W) ? {W{a[W-1]}} : W'(sa >>> b);
                v = r[W-1];
            end
            4'h6: begin
                r = (b >= W) ? '0 : (a >> b);
                v = r[W-1];
            end
            4'h8: begin
                r = p[W-1:0];
                c = p[63:32] != 0;
                v = c;
            end
            4'h9: r = p[63:32];
            4'hA: begin
                if (b == 0) begin r = '1; v = 1'b1; end
                else r = a / b;
            end
            4'hB: begin
                if (b == 0) begin r = a; v = 1'b1; end
                else r = a % b;
            end
            default: v = 1'b1;
        endcase
    endfunction

    // Drive one request; the model decides whether the DUT should accept it.
    task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit wf);
        int           e, d;
        exp_t         x;
        logic [W-1:0] r;
        logic         c, v;
        @(negedge clk);
        if (wf) while (edge_cnt < free_at) @(negedge clk);
        #2;
        start_i = 1'b1; func_i = f; in1_i = a; in2_i = b;
        @(posedge clk);
        e = edge_cnt;
        if (e >= free_at && !rst_i) begin
            model(f, a, b, r, c, v);
            d = (f >= 4'h8 && f <= 4'hB) ? W : 0;
            x.r = r; x.c = c; x.v = v; x.at = e + d + 1;
            scb.push_back(x);
            free_at = e + d + 1;
            last_e  = e;
            if (d != 0) busy_last = e + d;
        end
        #1 start_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            chk("busy", busy_o, edge_cnt <= busy_last);
            if (done_o) begin
                if (scb.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    mx = scb.pop_front();
                    chk("latency", edge_cnt, mx.at);
                    chk("out", out_o, mx.r);
                    chk("c", c_o, mx.c);
                    chk("v", v_o, mx.v);
                    chk("z", z_o, mx.r == 0);
                    chk("n", n_o, mx.r[W-1]);
                end
            end else if (scb.size() > 0 && edge_cnt > scb[0].at) begin
                chk("missing_done", 0, 1);
                void'(scb.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]   f;
        logic [W-1:0] a, b;
        int           n;
        rst_i = 1'b1; start_i = 1'b0; func_i = '0; in1_i = '0; in2_i = '0;
        s8 = 1'b0; f8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_out", out_o, 0);
        chk("rst_c", c_o, 0);
        chk("rst_v", v_o, 0);
        chk("rst_z", z_o, 1);
        chk("rst_n", n_o, 0);
        #3 rst_i = 1'b0;

        issue(4'h2, 32'h7FFF_FFFF, 32'h1, 1);
        issue(4'h3, 32'h0, 32'h1, 1);
        issue(4'h4, 32'h8000_0001, 32'd1, 1);
        issue(4'h5, 32'h8000_0000, 32'd40, 1);
        issue(4'h4, 32'hDEAD_BEEF, 32'd0, 1);
        issue(4'h4, 32'h0000_0003, 32'd32, 1);
        issue(4'h6, 32'h8000_0000, 32'd31, 1);
        issue(4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1);
        issue(4'h1, 32'hF000_0000, 32'h0000_000F, 1);
        issue(4'h7, 32'hAAAA_5555, 32'hFFFF_0000, 1);
        issue(4'h8, 32'h0001_0000, 32'h0001_0000, 1);
        issue(4'h9, 32'h0001_0000, 32'h0001_0000, 1);
        issue(4'h8, 32'd7, 32'd6, 1);
        issue(4'hA, 32'd100, 32'd7, 1);
        issue(4'hB, 32'd100, 32'd7, 1);
        issue(4'hA, 32'd5, 32'd0, 1);
        issue(4'hB, 32'd5, 32'd0, 1);
        for (int i = 12; i < 16; i++) issue(4'(i), 32'h1234, 32'h5678, 1);

        // Starts during an in-flight divide must be dropped.
        issue(4'hA, 32'd100, 32'd7, 1);
        issue(4'hB, 32'd9, 32'd2, 0);
        repeat (5) @(negedge clk);
        issue(4'h2, 32'd1, 32'd1, 0);

        for (int i = 0; i < 300; i++) begin
            f = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: a = '0;
                1: a = 32'h8000_0000;
                2: a = 32'h7FFF_FFFF;
                default: ;
            endcase
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'($urandom_range(0, 40));
                2: b = '1;
                3: b = 32'($urandom_range(1, 300));
                default: ;
            endcase
            repeat ($urandom_range(0, 3) == 0 ? 1 : 0) @(negedge clk);
            issue(f, a, b, $urandom_range(0, 3) != 0);
        end

        // Reset in the middle of an iterative op discards it.
        issue(4'hA, 32'd12345, 32'd0, 1);
        while (edge_cnt < last_e + 11) @(negedge clk);
        #3 rst_i = 1'b1;
        scb.delete();
        busy_last = -1;
        free_at = 0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_out", out_o, 0);
        chk("midrst_z", z_o, 1);
        @(negedge clk);
        #3 rst_i = 1'b0;
        issue(4'h8, 32'd123, 32'd456, 1);
        issue(4'h3, 32'd10, 32'd3, 1);

        n = 0;
        while (scb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", scb.size(), 0);

        @(negedge clk);
        s8 = 1'b1; f8 = 4'h8; a8 = 8'd15; b8 = 8'd17;
        @(posedge clk);
        #1 s8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("w8_latency", n, 9);
        chk("w8_out", out8, 8'd255);
        chk("w8_c", c8, 0);
        chk("w8_v", v8, 0);
        chk("w8_z", z8, 0);
        chk("w8_n", n8, 1);
        chk("w8_busy", busy8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
